quad_decoder: RTL
=================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FILT_LEN, default 3: consecutive cycles a synchronized input must hold a new level before acceptance; legal range 1..15.
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_in  input  1  quadrature channel A, asynchronous to clk.
REQ-006 b_in  input  1  quadrature channel B, asynchronous to clk.
REQ-007 enable  input  1  when 0, gates the ce and err outputs; tracking continues.
REQ-008 clr_err  input  1  synchronous clear of err_count.
REQ-009 ce  output  1  one-cycle step pulse, the count-enable for a downstream up/down counter.
REQ-010 up_down  output  1  step direction: 1 = up (forward), 0 = down; valid whenever ce=1.
REQ-011 err  output  1  one-cycle pulse on an illegal transition.
REQ-012 err_count  output  ERR_W  saturating count of illegal transitions.

Function
REQ-013 Each channel SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Filter: the filtered level SHALL change only after the synchronized level differs from it for FILT_LEN consecutive cycles; any cycle of agreement resets the run length to 0.
REQ-015 State SHALL be {a_f,b_f}; forward sequence 00->01->11->10->00, reverse is the inverse.
REQ-016 A forward single-bit state change SHALL give ce=1 and up_down=1 in the next cycle.
REQ-017 A reverse single-bit state change SHALL give ce=1 and up_down=0 in the next cycle.
REQ-018 Both filtered bits changing in the same cycle SHALL give err=1 and ce=0 in the next cycle; the new state is adopted and up_down is held.
REQ-019 up_down SHALL hold its last value between steps.
REQ-020 Latency: from the first rising edge that samples a new stable input level to ce/err high SHALL be exactly FILT_LEN+3 cycles.
REQ-021 Pulses of ce and err SHALL be exactly one cycle wide, and ce and err SHALL never be high together.
REQ-022 enable=0: ce and err forced to 0; filters, state and up_down keep tracking; err_count not incremented.
REQ-023 err_count SHALL increment on each err pulse and saturate at 2^ERR_W-1 with no wrap.
REQ-024 clr_err=1 SHALL set err_count to 0 next cycle; clr_err wins over a simultaneous err.
REQ-025 Settle window: for FILT_LEN+2 cycles after rst deasserts, the filters SHALL load the synchronized levels directly, with ce and err forced to 0, so the power-up input level never produces a step or error.

Reset
REQ-026 While rst=1: ce=0, err=0, up_down=1, err_count=0, synchronizers=0, filtered state=00, run-length counters=0, settle window restarted.
REQ-027 rst asserted mid-filter or mid-step SHALL discard the pending acceptance or pulse; no ce or err appears in the cycle after rst.

Structure
REQ-028 Package quad_pkg SHALL hold the state typedef (S00,S01,S11,S10), the direction constants DIR_UP=1 and DIR_DN=0, and the FILT_LEN range limits.
REQ-029 Sub-module quad_filter (synchronizer plus run-length filter, parameter FILT_LEN) SHALL be instantiated once per channel.
REQ-030 ce and up_down SHALL connect directly to the ce and up_down inputs of the team's up/down counter.

Verification
REQ-031 FILT_LEN=3, after settle, drive AB 00->01->11->10->00 with each level held 10 cycles -> 4 ce pulses, up_down=1, each 6 cycles after its edge.
REQ-032 Reverse sequence 00->10->11->01->00 -> 4 ce pulses with up_down=0; err_count stays 0.
REQ-033 Glitch of 2 cycles on A, FILT_LEN=3 -> no ce and no err.
REQ-034 AB 00->11 in the same cycle -> err=1 for 1 cycle, ce=0, err_count=1; repeat 300 times with ERR_W=8 -> err_count=255; clr_err concurrent with err -> err_count=0.
REQ-035 Inputs held at 11 through reset, and enable=0 during one forward step -> no ce or err after reset; state tracks the enable=0 step silently, and the next step with enable=1 gives exactly 1 ce.

Source files
------------

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared state encoding, direction constants and filter limits for the quadrature decoder
package quad_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } quad_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int FILT_LEN_MIN = 1;
  localparam int FILT_LEN_MAX = 15;
  localparam int RUN_W        = 4;

  function automatic int clamp_filt_len(input int len);
    if (len < FILT_LEN_MIN) return FILT_LEN_MIN;
    if (len > FILT_LEN_MAX) return FILT_LEN_MAX;
    return len;
  endfunction

  // Successor of a state in the forward (count-up) direction.
  function automatic quad_state_t fwd_next(input quad_state_t s);
    case (s)
      S00:     return S01;
      S01:     return S11;
      S11:     return S10;
      default: return S00;
    endcase
  endfunction

endpackage

// File: rtl/quad_filter.sv
// rtl/quad_filter.sv - two-flop synchronizer followed by a run-length level filter for one channel
module quad_filter
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic settle,
  output logic level
);

  localparam int              FL       = clamp_filt_len(FILT_LEN);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FL - 1);

  logic             sync1;
  logic             sync2;
  logic [RUN_W-1:0] run;

  // The level flips on the FL-th consecutive disagreeing sample; any agreement restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      run   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (settle) begin
        level <= sync2;
        run   <= '0;
      end else if (sync2 == level) begin
        run <= '0;
      end else if (run == RUN_LAST) begin
        level <= sync2;
        run   <= '0;
      end else begin
        run <= run + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder producing ce/up_down steps, error pulses and a saturating error count
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             enable,
  input  logic             clr_err,
  output logic             ce,
  output logic             up_down,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam int                  FL         = clamp_filt_len(FILT_LEN);
  localparam int                  SETTLE_W   = 5;
  localparam logic [SETTLE_W-1:0] SETTLE_LEN = SETTLE_W'(FL + 2);
  localparam logic [ERR_W-1:0]    ERR_MAX    = {ERR_W{1'b1}};

  logic [SETTLE_W-1:0] settle_cnt;
  logic                settle;
  logic                settle_q;
  logic                a_f;
  logic                b_f;
  quad_state_t         state_q;
  quad_state_t         state_n;
  logic [1:0]          diff;
  logic                fwd_n, rev_n, ill_n;
  logic                fwd_q, rev_q, ill_q;

  assign settle = (settle_cnt != '0);

  // settle_q stretches step suppression by one cycle so the decoder state catches the last settle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= SETTLE_LEN;
      settle_q   <= 1'b1;
    end else begin
      if (settle) settle_cnt <= settle_cnt - SETTLE_W'(1);
      settle_q <= settle;
    end
  end

  quad_filter #(.FILT_LEN(FL)) u_filt_a (
    .clk    (clk),
    .rst    (rst),
    .din    (a_in),
    .settle (settle),
    .level  (a_f)
  );

  quad_filter #(.FILT_LEN(FL)) u_filt_b (
    .clk    (clk),
    .rst    (rst),
    .din    (b_in),
    .settle (settle),
    .level  (b_f)
  );

  always_comb begin
    state_n = quad_state_t'({a_f, b_f});
    diff    = state_n ^ state_q;
    fwd_n   = 1'b0;
    rev_n   = 1'b0;
    ill_n   = 1'b0;
    if (!settle_q) begin
      fwd_n = (state_n == fwd_next(state_q));
      rev_n = (state_q == fwd_next(state_n));
      ill_n = (diff == 2'b11);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S00;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      fwd_q   <= fwd_n;
      rev_q   <= rev_n;
      ill_q   <= ill_n;
    end
  end

  // Direction keeps tracking with enable low; only the pulses and the error count are gated.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce        <= 1'b0;
      err       <= 1'b0;
      up_down   <= DIR_UP;
      err_count <= '0;
    end else begin
      ce  <= enable & (fwd_q | rev_q);
      err <= enable & ill_q;
      if (fwd_q)      up_down <= DIR_UP;
      else if (rev_q) up_down <= DIR_DN;
      if (clr_err)
        err_count <= '0;
      else if (enable && ill_q && (err_count != ERR_MAX))
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule
